// File: rtl/mem_check_fsm_pkg.sv
// Shared state type and default sizing for the memory read-back checker.
package mem_check_fsm_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_check_fsm_rd_addr_counter.sv
// Read address counter: clears to 0, increments on request, saturates at
// all-ones and flags that last location.
module rd_addr_counter
  import mem_check_fsm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  assign last_o = &addr_q;
  assign addr_o = addr_q;

  // Holding at all-ones keeps the counter from wrapping inside a run.
  always_comb begin
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = '0;
    end else if (inc_i && !last_o) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/mem_check_fsm.sv
// Reads every RAM location once in ascending order and checks for an
// identity fill (mem[i] == i), reporting error count and first bad address.
module mem_check_fsm
  import mem_check_fsm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic              wren,
  output logic              busy,
  output logic              stop,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_bad_addr
);

  localparam int ERR_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              tag_vld_q, tag_vld_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              pass_q, pass_d;

  logic              cnt_clr;
  logic              cnt_inc;
  logic              cnt_last;
  logic [ADDR_W-1:0] cnt_addr;
  logic              mismatch;

  rd_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_rd_addr_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .addr_o  (cnt_addr),
    .last_o  (cnt_last)
  );

  // q belongs to the address issued on the previous edge, carried by tag_q.
  assign mismatch = tag_vld_q && (q != DATA_W'(tag_q));

  always_comb begin
    state_d   = state_q;
    tag_d     = cnt_addr;
    tag_vld_d = 1'b0;
    err_d     = err_q;
    first_d   = first_q;
    pass_d    = pass_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    if (mismatch) begin
      err_d = err_q + ERR_W'(1);
      if (err_q == '0) begin
        first_d = tag_q;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          state_d = READ;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      READ: begin
        tag_vld_d = 1'b1;
        cnt_inc   = 1'b1;
        if (cnt_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // err_d already includes the compare of the last location.
        state_d = DONE;
        pass_d  = (err_d == '0);
      end
      DONE: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
      err_q     <= err_d;
      first_q   <= first_d;
      pass_q    <= pass_d;
    end
  end

  assign address        = cnt_addr;
  assign wren           = 1'b0;
  assign busy           = (state_q != IDLE);
  assign stop           = (state_q == DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_bad_addr = first_q;

endmodule
